// File: rtl/esn7e_st_pkg.sv
// Shared register map, field layout and helpers for the ESN sample sink.
package esn7e_st_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DROPS   = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int CTRL_THR_LSB = 8;
    localparam int THR_W        = 8;

    localparam int LEVEL_W  = 9;
    localparam int U_W      = 16;
    localparam int YHAT_W   = 16;
    localparam int SAMPLE_W = U_W + YHAT_W;

    typedef struct packed {
        logic [11:0]        rsvd_hi;
        logic               underflow;
        logic               overflow;
        logic               full;
        logic               empty;
        logic [6:0]         rsvd_lo;
        logic [LEVEL_W-1:0] level;
    } status_t;

    // A zero threshold would make irq permanently pending, so it behaves as 1.
    function automatic logic [THR_W-1:0] eff_thresh(input logic [THR_W-1:0] thr);
        return (thr == 8'd0) ? 8'd1 : thr;
    endfunction

endpackage

// File: rtl/esn7e_sample_fifo.sv
// Sample storage: circular buffer with one extra pointer bit so a full
// buffer (level == DEPTH) is distinguishable from an empty one.
module esn7e_sample_fifo
    import esn7e_st_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [DW-1:0]      push_data,
    input  logic               pop,
    output logic [DW-1:0]      head,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] level_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   diff_s, diff_nxt_s;
    logic [DW-1:0] mem_q [DEPTH];

    // Status decode and pointer advance; differences are kept at pointer width so they wrap correctly.
    always_comb begin
        diff_s = wr_ptr_q - rd_ptr_q;
        level  = LEVEL_W'(diff_s);
        full   = (diff_s == (AW+1)'(DEPTH));
        empty  = (diff_s == '0);
        head   = mem_q[rd_ptr_q[AW-1:0]];
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(push);
            rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        end
        diff_nxt_s = wr_ptr_d - rd_ptr_d;
        level_nxt  = LEVEL_W'(diff_nxt_s);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample memory, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/esn7e_st_sink.sv
// ESN sample sink: buffers streamed samples and exposes them, with status,
// drop counting and a fill-level interrupt, over a 4-word Avalon-MM slave.
module esn7e_st_sink
    import esn7e_st_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = SAMPLE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_valid,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    output logic [31:0]   avs_readdata,
    output logic          avs_readdatavalid,
    output logic          irq
);
    logic               full_s, empty_s, push_s, pop_s, flush_s, drop_s, avail_s;
    logic               rd_s, wr_s, ctrl_wr_s, data_rd_s, status_rd_s;
    logic [LEVEL_W-1:0] level_s, level_nxt_s;
    logic [DW-1:0]      head_s;
    status_t            status_s;
    logic               unused_wd_s;

    logic               enable_q, enable_d;
    logic [THR_W-1:0]   thr_q, thr_d;
    logic [31:0]        drops_q, drops_d;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rdv_q, rdv_d;
    logic               irq_q, irq_d;

    esn7e_sample_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (data_in),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s),
        .level_nxt (level_nxt_s)
    );

    // Access decode; a simultaneous read and write is treated as a read only.
    always_comb begin
        rd_s        = avs_read;
        wr_s        = avs_write & ~avs_read;
        ctrl_wr_s   = wr_s & (avs_address == ADDR_CONTROL);
        flush_s     = ctrl_wr_s & avs_writedata[CTRL_CLR_BIT];
        data_rd_s   = rd_s & (avs_address == ADDR_DATA);
        status_rd_s = rd_s & (avs_address == ADDR_STATUS);
        pop_s       = data_rd_s & ~empty_s;
        avail_s     = data_valid & enable_q & ~flush_s;
        push_s      = avail_s & (~full_s | pop_s);
        drop_s      = avail_s & full_s & ~pop_s;
        unused_wd_s = ^{avs_writedata[31:16], avs_writedata[7:2]};

        status_s           = '0;
        status_s.level     = level_s;
        status_s.empty     = empty_s;
        status_s.full      = full_s;
        status_s.overflow  = ovf_q;
        status_s.underflow = udf_q;
    end

    // Register-file next state; new sticky events win over a STATUS read-clear.
    always_comb begin
        enable_d = enable_q;
        thr_d    = thr_q;
        if (ctrl_wr_s) begin
            enable_d = avs_writedata[CTRL_EN_BIT];
            thr_d    = avs_writedata[CTRL_THR_LSB +: THR_W];
        end else begin
            enable_d = enable_q;
        end

        if (flush_s) begin
            drops_d = 32'd0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            drops_d = (drop_s && (drops_q != 32'hFFFF_FFFF)) ? drops_q + 32'd1 : drops_q;
            ovf_d   = (ovf_q & ~status_rd_s) | drop_s;
            udf_d   = (udf_q & ~status_rd_s) | (data_rd_s & empty_s);
        end

        rdata_d = rdata_q;
        if (rd_s) begin
            case (avs_address)
                ADDR_DATA:    rdata_d = empty_s ? 32'd0 : 32'(head_s);
                ADDR_STATUS:  rdata_d = status_s;
                ADDR_CONTROL: rdata_d = {16'd0, thr_q, 6'd0, 1'b0, enable_q};
                ADDR_DROPS:   rdata_d = drops_q;
                default:      rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end

        rdv_d = rd_s;
        irq_d = enable_d & (level_nxt_s >= {1'b0, eff_thresh(thr_d)});
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q <= 1'b0;
            thr_q    <= 8'd1;
            drops_q  <= 32'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rdv_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            thr_q    <= thr_d;
            drops_q  <= drops_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
            rdv_q    <= rdv_d;
            irq_q    <= irq_d;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdv_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_esn7e_st_sink.sv
// Bench for esn7e_st_sink: directed table, corner sequences and a random
// phase, all checked against a queue-based model of the sink.
module tb_esn7e_st_sink;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        irq;

    esn7e_st_sink #(.DEPTH(DEPTH), .DW(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .data_valid        (data_valid),
        .data_in           (data_in),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq [$];
    logic [31:0] m_drops;
    logic        m_ovf, m_udf, m_en, m_rdv;
    logic [7:0]  m_thr;
    logic [31:0] m_rdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        bit          dv;
        logic [31:0] din;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_drops = 32'd0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_en    = 1'b0;
        m_thr   = 8'd1;
        m_rdata = 32'd0;
        m_rdv   = 1'b0;
    endtask

    function automatic logic m_irq();
        int t;
        t = (m_thr == 8'd0) ? 1 : int'(m_thr);
        return m_en && (mq.size() >= t);
    endfunction

    // Apply the sink's rules to the currently driven inputs.
    task automatic m_step();
        bit rd, wr, clr, full, empty, pop, avail;
        rd    = avs_read;
        wr    = avs_write && !avs_read;
        clr   = wr && (avs_address == 2'd2) && avs_writedata[1];
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        pop   = rd && (avs_address == 2'd0) && !empty;
        avail = data_valid && m_en && !clr;
        m_rdv = rd;
        if (rd) begin
            case (avs_address)
                2'd0:    m_rdata = empty ? 32'd0 : mq[0];
                2'd1:    m_rdata = {12'd0, m_udf, m_ovf, full, empty, 7'd0, 9'(mq.size())};
                2'd2:    m_rdata = {16'd0, m_thr, 6'd0, 1'b0, m_en};
                default: m_rdata = m_drops;
            endcase
        end
        if (rd && avs_address == 2'd1) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (rd && avs_address == 2'd0 && empty) m_udf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (avail) begin
            if (!full || pop) mq.push_back(data_in);
            else begin
                m_ovf = 1'b1;
                if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
            end
        end
        if (wr && avs_address == 2'd2) begin
            m_en  = avs_writedata[0];
            m_thr = avs_writedata[15:8];
            if (clr) begin
                mq.delete();
                m_drops = 32'd0;
                m_ovf   = 1'b0;
                m_udf   = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
        chk("rdv", 32'(avs_readdatavalid), 32'(m_rdv));
        if (m_rdv) chk("rdata", avs_readdata, m_rdata);
        chk("irq", 32'(irq), 32'(m_irq()));
        avs_read   = 1'b0;
        avs_write  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        cycle();
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        avs_read = 1'b1; avs_address = a;
        cycle();
        chk(name, avs_readdata, exp);
    endtask

    task automatic push(input logic [31:0] d);
        data_valid = 1'b1; data_in = d;
        cycle();
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 2'd2, 32'h0000_0401, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h1000_0ABC, 1'b0, 32'h0,         1'b0};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h2000_0DEF, 1'b0, 32'h0,         1'b0};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0000_0003, 1'b0, 32'h0,         1'b0};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0,         1'b1};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1000_0ABC, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2000_0DEF, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'd1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b0};

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", avs_readdata, 32'd0);
        chk("reset_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        rd_chk(2'd2, 32'h0000_0100, "reset_control");

        // Pushes, FIFO order, read latency and threshold irq.
        for (int i = 0; i < 8; i++) begin
            avs_read = tbl[i].rd; avs_write = tbl[i].wr; avs_address = tbl[i].addr;
            avs_writedata = tbl[i].wd; data_valid = tbl[i].dv; data_in = tbl[i].din;
            cycle();
            if (tbl[i].chk_rd) chk("tbl_rdata", avs_readdata, tbl[i].exp_rd);
            chk("tbl_irq", 32'(irq), 32'(tbl[i].exp_irq));
        end

        // Overflow with drops, then push+pop on a full FIFO.
        wr_reg(2'd2, 32'h0000_0103);
        for (int k = 0; k < 20; k++) push(32'hA000_0000 + 32'(k));
        rd_chk(2'd1, 32'h0006_0010, "full_status");
        rd_chk(2'd3, 32'd4, "drops4");
        data_valid = 1'b1; data_in = 32'hB000_0000;
        rd_chk(2'd0, 32'hA000_0000, "full_pushpop_data");
        rd_chk(2'd1, 32'h0002_0010, "full_pushpop_status");
        rd_chk(2'd3, 32'd4, "drops_unchanged");

        // Underflow and its read-clear.
        wr_reg(2'd2, 32'h0000_0102);
        rd_chk(2'd0, 32'd0, "empty_data");
        rd_chk(2'd1, 32'h0009_0000, "underflow_set");
        rd_chk(2'd1, 32'h0001_0000, "underflow_cleared");

        // Reset with data stored and a read in flight.
        wr_reg(2'd2, 32'h0000_0101);
        for (int k = 0; k < 8; k++) push(32'hC000_0000 + 32'(k));
        avs_read = 1'b1; avs_address = 2'd0;
        m_step();
        @(posedge clk);
        #1;
        chk("mid_rdv", 32'(avs_readdatavalid), 32'd1);
        chk("mid_rdata", avs_readdata, 32'hC000_0000);
        avs_read = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_chk(2'd1, 32'h0001_0000, "post_rst_status");
        rd_chk(2'd3, 32'd0, "post_rst_drops");
        rd_chk(2'd2, 32'h0000_0100, "post_rst_control");
        for (int k = 0; k < 3; k++) push(32'hD000_0000 + 32'(k));
        rd_chk(2'd1, 32'h0001_0000, "disabled_ignored");
        wr_reg(2'd2, 32'h0000_0101);
        push(32'hE000_0000);
        rd_chk(2'd1, 32'h0000_0001, "reenabled_push");

        // Random traffic against the model.
        wr_reg(2'd2, 32'h0000_0303);
        for (int i = 0; i < 4000; i++) begin
            int r;
            data_valid = ($urandom_range(0, 9) < (((i / 400) % 2 == 1) ? 2 : 7));
            data_in    = $urandom();
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                avs_read      = 1'b1;
                avs_address   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
                avs_write     = (r < 4);
                avs_writedata = $urandom();
            end else if (r < 46) begin
                avs_write     = 1'b1;
                avs_address   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
                avs_writedata = {16'd0, 8'($urandom_range(0, 20)), 6'd0,
                                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0)};
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
